// File: rtl/tv80_bus_arbiter_pkg.sv
// Shared types for the TV80 bus arbiter: FSM state encoding, limits and the
// round-robin search used by the picker.
package tv80_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam logic [7:0] WDOG_LIMIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_CPU    = 3'd0,
    ST_REQ    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GRANT  = 3'd3,
    ST_REL    = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or after ptr, wrapping modulo nreq; ptr must be < nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [2:0] ptr,
                                    input int nreq);
    pick_t r;
    int k;
    r = '{valid: 1'b0, idx: 3'd0};
    // Scan from the far end so the closest hit to ptr is written last.
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (i < nreq) begin
        k = int'(ptr) + i;
        if (k >= nreq) k = k - nreq;
        if (req[k[2:0]]) begin
          r.valid = 1'b1;
          r.idx   = k[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tv80_bus_arbiter_if.sv
// Bus-sharing handshake between the arbiter (master modport) and the core,
// secondary masters and memory mux (slave modport).
interface tv80_bus_arbiter_if #(parameter int NREQ = 2) ();
  // i_req is a level held by a master until it is done; o_gnt is a registered
  // one-hot grant, and a master owns the bus exactly while its o_gnt bit is set.
  logic                     o_busrq_n;
  logic                     i_busak_n;
  logic [NREQ-1:0]          i_req;
  logic [NREQ-1:0]          o_gnt;
  logic                     o_cpu_owns;
  logic [2:0]               o_sel;
  logic                     o_timeout;
  tv80_arb_pkg::arb_state_e o_state;

  modport master (
    output o_busrq_n, o_gnt, o_cpu_owns, o_sel, o_timeout, o_state,
    input  i_busak_n, i_req
  );

  modport slave (
    input  o_busrq_n, o_gnt, o_cpu_owns, o_sel, o_timeout, o_state,
    output i_busak_n, i_req
  );
endinterface

// File: rtl/tv80_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or after ptr_i.
module tv80_rr_picker
  import tv80_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic            valid_o,
  output logic [2:0]      idx_o
);
  logic [MAX_NREQ-1:0] req_ext;
  pick_t               pick;

  assign req_ext = MAX_NREQ'(req_i);
  assign pick    = rr_pick(req_ext, ptr_i, NREQ);
  assign valid_o = pick.valid;
  assign idx_o   = pick.idx;
endmodule

// File: rtl/tv80_bus_arbiter.sv
// Parks the TV80 via BUSRQ_n/BUSAK_n and grants the bus round-robin to NREQ
// secondary masters. Optional grant watchdog: define TV80_ARB_WATCHDOG_EN.
module tv80_bus_arbiter
  import tv80_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SETTLE = 1
) (
  input logic              i_clk,
  input logic              i_reset_btn,
  tv80_bus_arbiter_if.master bus
);
  arb_state_e      state_q, state_d;
  logic            busrq_n_q, busrq_n_d;
  logic            cpu_owns_q, cpu_owns_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [1:0]      settle_q, settle_d;

  logic [NREQ-1:0] blocked, elig, sel_mask, pick_req;
  logic [2:0]      sel_inc, pick_ptr, pick_idx;
  logic            pick_valid, req_sel, wdog_hit, try_pick, go_rel, grant_load;

  assign elig     = bus.i_req & ~blocked;
  assign sel_mask = NREQ'(1'b1) << sel_q;
  assign req_sel  = |(bus.i_req & sel_mask);
  assign sel_inc  = (int'(sel_q) == NREQ - 1) ? 3'd0 : sel_q + 3'd1;

  // On a hand-over the outgoing master is excluded and the search starts just after it.
  assign pick_req = (state_q == ST_GRANT) ? (elig & ~sel_mask) : elig;
  assign pick_ptr = (state_q == ST_GRANT) ? sel_inc : ptr_q;

  tv80_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    busrq_n_d  = busrq_n_q;
    cpu_owns_d = cpu_owns_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    settle_d   = settle_q;
    try_pick   = 1'b0;
    go_rel     = 1'b0;
    grant_load = 1'b0;
    case (state_q)
      ST_CPU: begin
        if (|elig) begin
          busrq_n_d = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!(|elig)) begin
          go_rel = 1'b1;
        end else if (!bus.i_busak_n) begin
          if (SETTLE == 0) begin
            try_pick = 1'b1;
          end else begin
            settle_d = 2'd0;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == 2'(SETTLE - 1)) try_pick = 1'b1;
        else                            settle_d = settle_q + 2'd1;
      end
      ST_GRANT: begin
        if (!req_sel || wdog_hit) begin
          ptr_d    = sel_inc;
          try_pick = 1'b1;
        end
      end
      ST_REL: begin
        if (bus.i_busak_n) state_d = ST_CPU;
      end
      default: go_rel = 1'b1;
    endcase

    if (try_pick) begin
      if (pick_valid) begin
        gnt_d      = NREQ'(1'b1) << pick_idx;
        sel_d      = pick_idx;
        cpu_owns_d = 1'b0;
        state_d    = ST_GRANT;
        grant_load = 1'b1;
      end else begin
        go_rel = 1'b1;
      end
    end

    // Mux select returns to the core together with BUSRQ_n release.
    if (go_rel) begin
      gnt_d      = '0;
      sel_d      = 3'd0;
      cpu_owns_d = 1'b1;
      busrq_n_d  = 1'b1;
      state_d    = ST_REL;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset_btn) begin
    if (i_reset_btn) begin
      state_q    <= ST_CPU;
      busrq_n_q  <= 1'b1;
      cpu_owns_q <= 1'b1;
      gnt_q      <= '0;
      sel_q      <= 3'd0;
      ptr_q      <= 3'd0;
      settle_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      busrq_n_q  <= busrq_n_d;
      cpu_owns_q <= cpu_owns_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      settle_q   <= settle_d;
    end
  end

`ifdef TV80_ARB_WATCHDOG_EN
  logic [7:0]      wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
  logic [NREQ-1:0] blocked_q, blocked_d;

  assign wdog_hit = (wdog_q == WDOG_LIMIT);
  assign blocked  = blocked_q;

  // A revoked master stays masked until it lowers its request.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    blocked_d = blocked_q & bus.i_req;
    if (grant_load)                 wdog_d = 8'd0;
    else if (state_q == ST_GRANT)   wdog_d = wdog_q + 8'd1;
    if (state_q == ST_GRANT && wdog_hit) begin
      timeout_d = 1'b1;
      blocked_d = blocked_d | sel_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset_btn) begin
    if (i_reset_btn) begin
      wdog_q    <= 8'd0;
      timeout_q <= 1'b0;
      blocked_q <= '0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      blocked_q <= blocked_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign wdog_hit      = 1'b0;
  assign blocked       = '0;
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_busrq_n  = busrq_n_q;
  assign bus.o_gnt      = gnt_q;
  assign bus.o_cpu_owns = cpu_owns_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_state    = state_q;
endmodule
